spi_slave_regfile: RTL and testbench
====================================

Name: spi_slave_regfile

Overview:
Parametrised SPI slave (mode 0, MSB-first) clocked directly by the SPI serial clock. It exposes a DEPTH x DATA_W register file, written and read over SPI with a command byte and optional address auto-increment. It generalises the fixed-width display-style SPI slave, adding configurable word width and depth, multi-word bursts and read-back on MISO. Register contents are presented as parallel outputs to downstream logic such as display drivers or control fields.

Parameters:
DATA_W, 8, data word width in bits; legal range 8..32.
DEPTH, 8, number of registers; legal range 2..64.
RESET_VAL, 0, reset value of every register (DATA_W bits).
ADDR_W, clog2(DEPTH), derived localparam; not overridable.

Ports:
SPI_clk_x  in  1  SPI serial clock; the only clock.
HRESETn  in  1  reset, asynchronous, active-low.
SPI_ss_i  in  1  slave select, active-low.
SPI_mosi_i  in  1  serial data in, sampled on rising edge.
SPI_miso_o  out  1  serial data out, updated on falling edge.
reg_data_o  out  DEPTH*DATA_W  register file, reg[i] at bits [i*DATA_W +: DATA_W].
wr_addr_o  out  ADDR_W  address of the most recent committed write.
wr_toggle_o  out  1  inverts once per committed write word; CDC-safe event.
busy_o  out  1  high while a transaction is past its command byte.

Behaviour:
- Reset (HRESETn low, async):
  - all registers = RESET_VAL; wr_addr_o = 0; wr_toggle_o = 0; busy_o = 0; SPI_miso_o = 0.
  - state = CMD; bit counter = 0.
  - Reset mid-transaction aborts it; no partial commit.
- SPI_ss_i high acts as an asynchronous clear of transaction state only:
  - state = CMD, bit counter = 0, busy_o = 0, SPI_miso_o = 0.
  - Registers, wr_addr_o and wr_toggle_o hold their values.
- Command byte (first 8 rising edges after SS falls), MSB first:
  - bit7 R/W: 1 = read.
  - bit6 INC: 1 = auto-increment.
  - bits[5:0] ADDR: bits above ADDR_W must be 0, otherwise the address is out of range.
- State machine: CMD -> WRITE or READ on the 8th rising edge. WRITE and READ persist until SS rises. busy_o = (state != CMD).
- WRITE:
  - MOSI shifts into an rx register.
  - On every DATA_W-th data rising edge: reg[addr] <= word; wr_addr_o <= addr; wr_toggle_o inverts.
  - Then addr advances if INC.
  - Out-of-range addr: the word is discarded, and neither wr_addr_o nor wr_toggle_o changes.
- READ:
  - On the 8th command rising edge, tx_sr loads reg[addr] (0 if out of range).
  - SPI_miso_o captures tx_sr MSB on each falling edge; tx_sr shifts left on each rising edge.
  - On the last bit of each word, tx_sr reloads from the next addr (INC) or the same addr.
  - SPI_miso_o = 0 during the command phase.
- Auto-increment wraps from DEPTH-1 to 0. With INC=0, consecutive words target the same register.
- Partial word (SS rises before DATA_W bits complete): discarded; registers are unchanged.
- Latency:
  - Write data is visible on reg_data_o at the rising edge of its last bit.
  - First read bit is valid on MISO after the falling edge following the 8th command bit.
- The consumer synchronises reg_data_o using wr_toggle_o edges. Words are stable once the toggle is seen.

Decomposition:
- Package spi_regfile_pkg:
  - CMD_W = 8, CMD_RD_BIT = 7, CMD_INC_BIT = 6, CMD_ADDR_LSB = 0.
  - state enum {CMD, WRITE, READ}.
- Sub-module spi_bit_engine:
  - holds the bit counter, rx shift register, tx shift register and negedge MISO register;
  - emits a word_done strobe and the received word.
- spi_slave_regfile keeps the command decode, address pointer, register file and toggle.

Test Plan:
1. Pulse HRESETn low with DATA_W=8, DEPTH=8 -> all reg_data_o = 0, SPI_miso_o = 0, wr_toggle_o = 0, busy_o = 0.
2. SS low, send 0x03 then 0xA5, SS high -> reg[3] = 0xA5, wr_addr_o = 3, wr_toggle_o = 1, other registers 0.
3. Send 0x46 then 0x11, 0x22, 0x33 -> reg[6] = 0x11, reg[7] = 0x22, reg[0] = 0x33 (wrap); wr_toggle_o toggles 3 times.
4. Send 0xC6 and clock 24 data bits with MOSI = 0 -> MISO sampled on rising edges yields 0x11, 0x22, 0x33; registers unchanged.
5. Send 0x01, then 5 bits, SS high -> reg[1] unchanged and wr_toggle_o unchanged.
   - Next transaction 0x01, 0x5A -> reg[1] = 0x5A.
6. Out-of-range address and reset mid-burst:
   - Write 0x0A, 0xFF -> no register change, no toggle.
   - Read 0x8A -> MISO returns 0x00.
   - Reset asserted mid-burst -> all registers = RESET_VAL.

Source files
------------

// File: rtl/spi_slave_regfile_pkg.sv
// Shared constants and types for the SPI register-file slave.
package spi_regfile_pkg;

  // Command byte layout, MSB first on the wire.
  localparam int CMD_W        = 8;
  localparam int CMD_RD_BIT   = 7;
  localparam int CMD_INC_BIT  = 6;
  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_ADDR_W   = 6;

  // Bit counter wide enough for the largest legal word (32 bits).
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    CMD   = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_bit_engine.sv
// Serial bit engine: bit counter, rx/tx shift registers and the
// falling-edge MISO register. All state here belongs to the current
// transaction and is cleared whenever txn_rst_n is low.
module spi_bit_engine
  import spi_regfile_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              SPI_clk_x,
  input  logic              txn_rst_n,
  input  logic              SPI_mosi_i,
  input  logic              data_phase,
  input  logic              rd_phase,
  input  logic              tx_load,
  input  logic [DATA_W-1:0] tx_word,
  output logic              cmd_done,
  output logic              word_done,
  output logic [DATA_W-1:0] rx_word,
  output logic              SPI_miso_o
);

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;

  // The incoming bit is appended combinationally so the full word is
  // available on the very edge that samples its last bit.
  assign rx_word   = {rx_sr, SPI_mosi_i};
  assign cmd_done  = !data_phase && (bit_cnt == CNT_W'(CMD_W - 1));
  assign word_done = data_phase && (bit_cnt == CNT_W'(DATA_W - 1));

  // Bit counter: counts the command byte, then each data word.
  always_ff @(posedge SPI_clk_x or negedge txn_rst_n) begin
    if (!txn_rst_n) begin
      bit_cnt <= '0;
    end else if (cmd_done || word_done) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Receive shift register, MSB first.
  always_ff @(posedge SPI_clk_x or negedge txn_rst_n) begin
    if (!txn_rst_n) begin
      rx_sr <= '0;
    end else begin
      rx_sr <= rx_word[DATA_W-2:0];
    end
  end

  // Transmit shift register: load a fresh word or shift left.
  always_ff @(posedge SPI_clk_x or negedge txn_rst_n) begin
    if (!txn_rst_n) begin
      tx_sr <= '0;
    end else if (tx_load) begin
      tx_sr <= tx_word;
    end else begin
      tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
    end
  end

  // MISO changes on the falling edge so the master samples it stable.
  always_ff @(negedge SPI_clk_x or negedge txn_rst_n) begin
    if (!txn_rst_n) begin
      SPI_miso_o <= 1'b0;
    end else begin
      SPI_miso_o <= rd_phase ? tx_sr[DATA_W-1] : 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave exposing a DEPTH x DATA_W register file with
// command-byte addressing, burst auto-increment and MISO read-back.
//
// Event protocol toward the consumer: wr_toggle_o inverts once per
// committed write word; the word in reg_data_o at wr_addr_o is stable
// by the time the consumer observes the toggle edge after synchronising it.
module spi_slave_regfile
  import spi_regfile_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              DEPTH     = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int             ADDR_W    = $clog2(DEPTH)
) (
  input  logic                    SPI_clk_x,
  input  logic                    HRESETn,
  input  logic                    SPI_ss_i,
  input  logic                    SPI_mosi_i,
  output logic                    SPI_miso_o,
  output logic [DEPTH*DATA_W-1:0] reg_data_o,
  output logic [ADDR_W-1:0]       wr_addr_o,
  output logic                    wr_toggle_o,
  output logic                    busy_o
);

  // Transaction state clears on reset or whenever slave select is high.
  logic txn_rst_n;
  assign txn_rst_n = HRESETn & ~SPI_ss_i;

  state_t                state_q, state_d;
  logic                  cmd_done, word_done, tx_load;
  logic [DATA_W-1:0]     rx_word, tx_word;
  logic [CMD_W-1:0]      cmd_byte;
  logic [CMD_ADDR_W-1:0] cmd_addr;
  logic                  cmd_oor;
  logic [ADDR_W-1:0]     addr_q, next_addr;
  logic                  oor_q, inc_q;
  logic [DATA_W-1:0]     regs [DEPTH];

  assign cmd_byte = rx_word[CMD_W-1:0];
  assign cmd_addr = cmd_byte[CMD_ADDR_LSB +: CMD_ADDR_W];
  assign cmd_oor  = int'(cmd_addr) >= DEPTH;
  assign busy_o   = (state_q != CMD);
  assign tx_load  = (cmd_done && cmd_byte[CMD_RD_BIT]) || (word_done && state_q == READ);

  spi_bit_engine #(.DATA_W(DATA_W)) u_engine (
    .SPI_clk_x  (SPI_clk_x),
    .txn_rst_n  (txn_rst_n),
    .SPI_mosi_i (SPI_mosi_i),
    .data_phase (busy_o),
    .rd_phase   (state_q == READ),
    .tx_load    (tx_load),
    .tx_word    (tx_word),
    .cmd_done   (cmd_done),
    .word_done  (word_done),
    .rx_word    (rx_word),
    .SPI_miso_o (SPI_miso_o)
  );

  // State register.
  always_ff @(posedge SPI_clk_x or negedge txn_rst_n) begin
    if (!txn_rst_n) begin
      state_q <= CMD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave CMD once the command byte is complete.
  always_comb begin
    state_d = state_q;
    if (state_q == CMD && cmd_done) begin
      state_d = cmd_byte[CMD_RD_BIT] ? READ : WRITE;
    end
  end

  // Address of the word after the current one, wrapping at DEPTH-1.
  always_comb begin
    next_addr = addr_q;
    if (inc_q) begin
      next_addr = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  // Word to present on MISO next; out-of-range addresses read as zero.
  always_comb begin
    tx_word = '0;
    if (cmd_done) begin
      if (!cmd_oor) tx_word = regs[cmd_addr[ADDR_W-1:0]];
    end else if (!oor_q) begin
      tx_word = regs[next_addr];
    end
  end

  // Address pointer, captured from the command and stepped per word.
  // An out-of-range command stays out of range for the whole burst.
  always_ff @(posedge SPI_clk_x or negedge txn_rst_n) begin
    if (!txn_rst_n) begin
      addr_q <= '0;
      oor_q  <= 1'b0;
      inc_q  <= 1'b0;
    end else if (cmd_done) begin
      addr_q <= cmd_addr[ADDR_W-1:0];
      oor_q  <= cmd_oor;
      inc_q  <= cmd_byte[CMD_INC_BIT];
    end else if (word_done) begin
      addr_q <= next_addr;
    end
  end

  // Register file commit; only a full word in WRITE at a valid address lands.
  always_ff @(posedge SPI_clk_x or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
      wr_addr_o   <= '0;
      wr_toggle_o <= 1'b0;
    end else if (word_done && state_q == WRITE && !oor_q) begin
      regs[addr_q] <= rx_word;
      wr_addr_o    <= addr_q;
      wr_toggle_o  <= ~wr_toggle_o;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign reg_data_o[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed and randomised bench for spi_slave_regfile with a
// transaction-level register model.
module tb_spi_slave_regfile;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] RESET_VAL = '0;

  // ---------------- clock / reset / DUT ----------------
  logic                    SPI_clk_x  = 1'b0;
  logic                    HRESETn    = 1'b0;
  logic                    SPI_ss_i   = 1'b1;
  logic                    SPI_mosi_i = 1'b0;
  logic                    SPI_miso_o;
  logic [DEPTH*DATA_W-1:0] reg_data_o;
  logic [ADDR_W-1:0]       wr_addr_o;
  logic                    wr_toggle_o;
  logic                    busy_o;

  spi_slave_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL)) dut (
    .SPI_clk_x   (SPI_clk_x),
    .HRESETn     (HRESETn),
    .SPI_ss_i    (SPI_ss_i),
    .SPI_mosi_i  (SPI_mosi_i),
    .SPI_miso_o  (SPI_miso_o),
    .reg_data_o  (reg_data_o),
    .wr_addr_o   (wr_addr_o),
    .wr_toggle_o (wr_toggle_o),
    .busy_o      (busy_o)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] model_regs [DEPTH];
  logic [ADDR_W-1:0] model_wr_addr;
  logic              model_toggle;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] tx_q  [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_regs[i] = RESET_VAL;
    model_wr_addr = '0;
    model_toggle  = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [DEPTH*DATA_W-1:0] model_packed();
    logic [DEPTH*DATA_W-1:0] p;
    for (int i = 0; i < DEPTH; i++) p[i*DATA_W +: DATA_W] = model_regs[i];
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  // One SPI bit: MOSI set while SCK low, MISO sampled just before the rise.
  task automatic spi_bit(input logic b, output logic sampled);
    SPI_mosi_i = b;
    #10;
    sampled = SPI_miso_o;
    SPI_clk_x = 1'b1;
    #10;
    SPI_clk_x = 1'b0;
  endtask

  task automatic shift_word(input logic [DATA_W-1:0] w, input int nbits, output logic [DATA_W-1:0] rd);
    logic s;
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(w[DATA_W-1-i], s);
      rd = {rd[DATA_W-2:0], s};
    end
  endtask

  task automatic send_cmd(input logic [7:0] cmd, output logic [7:0] miso_bits);
    logic s;
    miso_bits = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("busy_in_cmd", 64'(busy_o), 64'h0);
      spi_bit(cmd[7-i], s);
      miso_bits = {miso_bits[6:0], s};
    end
  endtask

  // Full transaction: command byte, every word in tx_q, then tail_bits of
  // a partial word. The model is advanced from the command rules first.
  task automatic run_txn(input logic [7:0] cmd, input int tail_bits);
    int a;
    logic [7:0]        cmd_miso;
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] got_words [$];
    a = int'(cmd[5:0]);
    foreach (tx_q[k]) begin
      if (cmd[7]) begin
        if (a < DEPTH) exp_q.push_back(model_regs[a]);
        else           exp_q.push_back('0);
      end else if (a < DEPTH) begin
        model_regs[a] = tx_q[k];
        model_wr_addr = ADDR_W'(a);
        model_toggle  = ~model_toggle;
      end
      if (cmd[6] && a < DEPTH) a = (a + 1) % DEPTH;
    end

    SPI_ss_i = 1'b0;
    #10;
    send_cmd(cmd, cmd_miso);
    check("miso_cmd_phase", 64'(cmd_miso), 64'h0);
    check("busy_after_cmd", 64'(busy_o), 64'h1);
    foreach (tx_q[k]) begin
      shift_word(tx_q[k], DATA_W, got);
      if (cmd[7]) got_words.push_back(got);
    end
    if (tail_bits > 0) shift_word(DATA_W'($urandom), tail_bits, got);
    #5;
    SPI_ss_i = 1'b1;
    #1;
    check("busy_after_ss", 64'(busy_o), 64'h0);
    check("miso_after_ss", 64'(SPI_miso_o), 64'h0);
    #9;
    foreach (got_words[k]) check("read_word", 64'(got_words[k]), 64'(exp_q.pop_front()));
    check("reg_data", 64'(reg_data_o), 64'(model_packed()));
    check("wr_toggle", 64'(wr_toggle_o), 64'(model_toggle));
    check("wr_addr", 64'(wr_addr_o), 64'(model_wr_addr));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_regs"}, 64'(reg_data_o), 64'({DEPTH{RESET_VAL}}));
    check({tag, "_miso"}, 64'(SPI_miso_o), 64'h0);
    check({tag, "_toggle"}, 64'(wr_toggle_o), 64'h0);
    check({tag, "_busy"}, 64'(busy_o), 64'h0);
    check({tag, "_wr_addr"}, 64'(wr_addr_o), 64'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0]        cmd;
    logic [7:0]        cmd_miso;
    logic [DATA_W-1:0] got;
    int                nw;
    int                tail;

    model_reset();
    #20;
    check_reset_state("reset_held");
    HRESETn = 1'b1;
    #20;
    check_reset_state("reset_released");

    // Single write.
    tx_q = '{8'hA5};
    run_txn(8'h03, 0);
    check("reg3_a5", 64'(reg_data_o[3*DATA_W +: DATA_W]), 64'hA5);

    // Auto-increment burst wrapping 7 -> 0.
    tx_q = '{8'h11, 8'h22, 8'h33};
    run_txn(8'h46, 0);
    check("reg0_wrap", 64'(reg_data_o[0 +: DATA_W]), 64'h33);

    // Read-back burst.
    tx_q = '{8'h00, 8'h00, 8'h00};
    run_txn(8'hC6, 0);

    // Partial word is discarded, then a full word lands.
    tx_q.delete();
    run_txn(8'h01, 5);
    tx_q = '{8'h5A};
    run_txn(8'h01, 0);
    check("reg1_5a", 64'(reg_data_o[1*DATA_W +: DATA_W]), 64'h5A);

    // Out-of-range write and read.
    tx_q = '{8'hFF};
    run_txn(8'h0A, 0);
    tx_q = '{8'h00};
    run_txn(8'h8A, 0);

    // Non-incrementing burst hits the same register.
    tx_q = '{8'h12, 8'h34};
    run_txn(8'h05, 0);

    // Random mix of reads, writes, bursts and partial tails.
    for (int t = 0; t < 40; t++) begin
      cmd = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b00, 4'($urandom_range(0, 15))};
      nw  = $urandom_range(0, 4);
      tail = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DATA_W - 1) : 0;
      tx_q.delete();
      for (int k = 0; k < nw; k++) tx_q.push_back(DATA_W'($urandom));
      run_txn(cmd, tail);
    end

    // Reset in the middle of a burst.
    SPI_ss_i = 1'b0;
    #10;
    send_cmd(8'h40, cmd_miso);
    shift_word(8'h77, DATA_W, got);
    model_regs[0] = 8'h77;
    model_wr_addr = '0;
    model_toggle  = ~model_toggle;
    #1;
    check("midburst_commit", 64'(reg_data_o), 64'(model_packed()));
    shift_word(8'hE0, 3, got);
    HRESETn = 1'b0;
    #1;
    model_reset();
    check_reset_state("midburst_reset");
    #10;
    HRESETn = 1'b1;
    #5;
    SPI_ss_i = 1'b1;
    #10;
    check("after_reset_regs", 64'(reg_data_o), 64'(model_packed()));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
